// File: rtl/avalon_multi_timer.sv
// Avalon-MM multi-channel down-counting interval timer with a combined interrupt.
// Define TIMER_PWM_EN to add per-channel compare registers (addresses 6/7) and PWM outputs.
module avalon_multi_timer #(
    parameter int          NUM_CH       = 2,
    parameter int          CNT_W        = 32,
    parameter logic [31:0] PERIOD_RESET = 32'h1869F
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [4:0]        address,
    input  logic [15:0]       writedata,
    output logic [15:0]       readdata,
    output logic              irq,
    output logic [NUM_CH-1:0] pwm_out
);
    localparam logic [CNT_W-1:0] CNT_RESET = PERIOD_RESET[CNT_W-1:0];

    logic              wr_en;
    logic [15:0]       rd_ch [4];
    logic [NUM_CH-1:0] irq_ch;

    assign wr_en = chipselect & ~write_n;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] counter_reg;
            logic [CNT_W-1:0] period_reg;
            logic [CNT_W-1:0] snapshot_reg;
            logic             ito_reg;
            logic             cont_reg;
            logic             to_reg;
            logic             run_reg;
            logic             reload_reg;
            logic             zero_prev_reg;
            logic             sel;
            logic             zero;
            logic [31:0]      period_ext;
            logic [31:0]      snapshot_ext;
            logic [31:0]      compare_ext;
            logic [15:0]      rd_word;

            assign sel          = wr_en && (address[4:3] == 2'(gi));
            assign zero         = (counter_reg == '0);
            assign period_ext   = 32'(period_reg);
            assign snapshot_ext = 32'(snapshot_reg);
            assign irq_ch[gi]   = to_reg & ito_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    counter_reg   <= CNT_RESET;
                    period_reg    <= CNT_RESET;
                    snapshot_reg  <= '0;
                    ito_reg       <= 1'b0;
                    cont_reg      <= 1'b0;
                    to_reg        <= 1'b0;
                    run_reg       <= 1'b0;
                    reload_reg    <= 1'b0;
                    zero_prev_reg <= (CNT_RESET == '0);
                end else begin
                    reload_reg    <= sel && (address[2:1] == 2'd1);
                    zero_prev_reg <= zero;

                    // One-shot mode parks the counter at zero instead of reloading.
                    if (reload_reg) begin
                        counter_reg <= period_reg;
                    end else if (run_reg) begin
                        if (!zero) begin
                            counter_reg <= counter_reg - CNT_W'(1);
                        end else if (cont_reg) begin
                            counter_reg <= period_reg;
                        end
                    end

                    // Automatic clears first so a START strobe in the same cycle overrides them.
                    if (reload_reg || (zero && !cont_reg)) begin
                        run_reg <= 1'b0;
                    end
                    if (sel && (address[2:0] == 3'd1)) begin
                        ito_reg  <= writedata[0];
                        cont_reg <= writedata[1];
                        if (writedata[2]) begin
                            run_reg <= 1'b1;
                        end else if (writedata[3]) begin
                            run_reg <= 1'b0;
                        end
                    end

                    if (sel && (address[2:0] == 3'd0)) begin
                        to_reg <= 1'b0;
                    end else if (zero && !zero_prev_reg) begin
                        to_reg <= 1'b1;
                    end

                    if (sel && (address[2:0] == 3'd2)) begin
                        period_reg[15:0] <= writedata;
                    end
                    if (sel && (address[2:0] == 3'd3)) begin
                        period_reg[CNT_W-1:16] <= writedata[CNT_W-17:0];
                    end
                    if (sel && (address[2:1] == 2'd2)) begin
                        snapshot_reg <= counter_reg;
                    end
                end
            end

`ifdef TIMER_PWM_EN
            logic [CNT_W-1:0] compare_reg;
            logic             pwm_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    compare_reg <= '0;
                    pwm_reg     <= 1'b0;
                end else begin
                    pwm_reg <= run_reg && (counter_reg < compare_reg);
                    if (sel && (address[2:0] == 3'd6)) begin
                        compare_reg[15:0] <= writedata;
                    end
                    if (sel && (address[2:0] == 3'd7)) begin
                        compare_reg[CNT_W-1:16] <= writedata[CNT_W-17:0];
                    end
                end
            end

            assign compare_ext = 32'(compare_reg);
            assign pwm_out[gi] = pwm_reg;
`else
            assign compare_ext = '0;
            assign pwm_out[gi] = 1'b0;
`endif

            always_comb begin
                rd_word = 16'h0000;
                case (address[2:0])
                    3'd0:    rd_word = {14'h0000, run_reg, to_reg};
                    3'd1:    rd_word = {14'h0000, cont_reg, ito_reg};
                    3'd2:    rd_word = period_ext[15:0];
                    3'd3:    rd_word = period_ext[31:16];
                    3'd4:    rd_word = snapshot_ext[15:0];
                    3'd5:    rd_word = snapshot_ext[31:16];
                    3'd6:    rd_word = compare_ext[15:0];
                    3'd7:    rd_word = compare_ext[31:16];
                    default: rd_word = 16'h0000;
                endcase
            end

            assign rd_ch[gi] = rd_word;
        end

        // Unpopulated channel slots read as zero.
        for (gi = NUM_CH; gi < 4; gi++) begin : g_unused
            assign rd_ch[gi] = 16'h0000;
        end
    endgenerate

    assign irq = |irq_ch;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= 16'h0000;
        end else begin
            readdata <= rd_ch[address[4:3]];
        end
    end
endmodule

// File: tb/tb_avalon_multi_timer.sv
// Self-checking bench for avalon_multi_timer: reset vector table, scoreboarded reads,
// and hand-written timing sequences for timeout, one-shot, reload, PWM and NUM_CH=1.
module tb_avalon_multi_timer;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        chipselect;
    logic        cs_one;
    logic        write_n;
    logic [4:0]  address;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic [15:0] readdata_one;
    logic        irq;
    logic        irq_one;
    logic [1:0]  pwm_out;
    logic [0:0]  pwm_one;

    always #5 clk = ~clk;

    avalon_multi_timer u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .chipselect (chipselect),
        .write_n    (write_n),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .pwm_out    (pwm_out)
    );

    avalon_multi_timer #(.NUM_CH(1)) u_one (
        .clk        (clk),
        .reset_n    (reset_n),
        .chipselect (cs_one),
        .write_n    (write_n),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata_one),
        .irq        (irq_one),
        .pwm_out    (pwm_one)
    );

    typedef struct {
        string       name;
        logic [15:0] exp;
        bit          one;
    } sb_item_t;

    typedef struct {
        logic [4:0]  addr;
        logic [15:0] exp;
        string       name;
    } vec_t;

    sb_item_t sb[$];
    sb_item_t mon_item;
    vec_t     vecs[10];
    int       errors = 0;
    int       checks = 0;
    bit       rd_valid = 1'b0;
    bit       tgt_one = 1'b0;

`ifdef TIMER_PWM_EN
    localparam logic [15:0] CMP_READ  = 16'h0004;
    localparam logic [15:0] PWM_HIGHS = 16'd8;
`else
    localparam logic [15:0] CMP_READ  = 16'h0000;
    localparam logic [15:0] PWM_HIGHS = 16'd0;
`endif

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%04h", name, act);
        end
    endtask

    // Each bus task occupies exactly one clock edge and returns 1 ns after it.
    task automatic bus(input logic cs, input logic wn, input logic [4:0] a, input logic [15:0] d,
                       input bit is_rd);
        @(negedge clk);
        chipselect = cs & ~tgt_one;
        cs_one     = cs & tgt_one;
        write_n    = wn;
        address    = a;
        writedata  = d;
        rd_valid   = is_rd;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [15:0] d);
        bus(1'b1, 1'b0, a, d, 1'b0);
    endtask

    task automatic tick();
        bus(1'b0, 1'b1, address, 16'h0000, 1'b0);
    endtask

    task automatic rd(input logic [4:0] a, input logic [15:0] exp, input string name);
        sb_item_t it;
        it.name = name;
        it.exp  = exp;
        it.one  = tgt_one;
        sb.push_back(it);
        bus(1'b1, 1'b1, a, 16'h0000, 1'b1);
    endtask

    // Read data is registered, so a read issued on an edge is checked just after that edge.
    always @(posedge clk) begin
        if (rd_valid) begin
            #1;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got read with no expectation, readdata 0x%04h", readdata);
            end else begin
                mon_item = sb.pop_front();
                chk(mon_item.name, mon_item.one ? readdata_one : readdata, mon_item.exp);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int highs;

        vecs[0] = '{addr: 5'h00, exp: 16'h0000, name: "rst_ch0_status"};
        vecs[1] = '{addr: 5'h01, exp: 16'h0000, name: "rst_ch0_control"};
        vecs[2] = '{addr: 5'h02, exp: 16'h869F, name: "rst_ch0_period_lo"};
        vecs[3] = '{addr: 5'h03, exp: 16'h0001, name: "rst_ch0_period_hi"};
        vecs[4] = '{addr: 5'h04, exp: 16'h0000, name: "rst_ch0_snap_lo"};
        vecs[5] = '{addr: 5'h05, exp: 16'h0000, name: "rst_ch0_snap_hi"};
        vecs[6] = '{addr: 5'h0A, exp: 16'h869F, name: "rst_ch1_period_lo"};
        vecs[7] = '{addr: 5'h0B, exp: 16'h0001, name: "rst_ch1_period_hi"};
        vecs[8] = '{addr: 5'h12, exp: 16'h0000, name: "rst_ch2_absent"};
        vecs[9] = '{addr: 5'h06, exp: 16'h0000, name: "rst_ch0_compare_lo"};

        reset_n    = 1'b0;
        chipselect = 1'b0;
        cs_one     = 1'b0;
        write_n    = 1'b1;
        address    = 5'h00;
        writedata  = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_irq", {15'h0000, irq}, 16'h0000);
        chk("rst_pwm", {14'h0000, pwm_out}, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            rd(vecs[i].addr, vecs[i].exp, vecs[i].name);
        end
        tick();

        // ch1 continuous: period 5, ITO|CONT|START on edge E0.
        wr(5'h0A, 16'd5);
        wr(5'h0B, 16'd0);
        tick();
        wr(5'h09, 16'h0007);
        repeat (5) tick();
        chk("ch1_irq_before_timeout", {15'h0000, irq}, 16'h0000);
        tick();
        chk("ch1_irq_after_timeout", {15'h0000, irq}, 16'h0001);
        rd(5'h08, 16'h0003, "ch1_status_to_run");
        wr(5'h08, 16'h0000);
        chk("ch1_irq_cleared", {15'h0000, irq}, 16'h0000);
        repeat (3) tick();
        chk("ch1_irq_rearm_before", {15'h0000, irq}, 16'h0000);
        tick();
        chk("ch1_irq_rearm_6cyc", {15'h0000, irq}, 16'h0001);
        wr(5'h08, 16'h0000);
        repeat (4) tick();
        wr(5'h08, 16'h0000);
        chk("ch1_irq_clear_wins", {15'h0000, irq}, 16'h0000);
        rd(5'h08, 16'h0002, "ch1_status_clear_wins");

        // Period write while running: reload and stop on the following cycle.
        wr(5'h0A, 16'd7);
        tick();
        rd(5'h08, 16'h0000, "ch1_run_dropped");
        wr(5'h0C, 16'h0000);
        rd(5'h0C, 16'h0007, "ch1_snap_new_period");
        rd(5'h0D, 16'h0000, "ch1_snap_hi");

        // ch0 one-shot: period 3, ITO|START.
        wr(5'h02, 16'd3);
        wr(5'h03, 16'd0);
        tick();
        wr(5'h01, 16'h0005);
        tick();
        wr(5'h04, 16'h0000);
        rd(5'h04, 16'h0002, "ch0_snap_mid_count");
        rd(5'h00, 16'h0002, "ch0_running");
        rd(5'h00, 16'h0001, "ch0_oneshot_done");
        chk("ch0_irq_oneshot", {15'h0000, irq}, 16'h0001);
        wr(5'h04, 16'h0000);
        rd(5'h04, 16'h0000, "ch0_counter_stays_zero");
        wr(5'h00, 16'h0000);
        chk("ch0_irq_cleared", {15'h0000, irq}, 16'h0000);

        // Compare / PWM: period 9, compare 4, CONT|START.
        wr(5'h06, 16'd4);
        wr(5'h07, 16'd0);
        rd(5'h06, CMP_READ, "ch0_compare_lo");
        rd(5'h07, 16'h0000, "ch0_compare_hi");
        wr(5'h02, 16'd9);
        wr(5'h03, 16'd0);
        tick();
        wr(5'h01, 16'h0006);
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            highs += int'(pwm_out[0]);
        end
        chk("ch0_pwm_duty_20cyc", 16'(highs), PWM_HIGHS);
        chk("ch1_pwm_idle", {15'h0000, pwm_out[1]}, 16'h0000);

        // Asynchronous reset mid-count.
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_pwm", {14'h0000, pwm_out}, 16'h0000);
        chk("midrst_irq", {15'h0000, irq}, 16'h0000);
        chk("midrst_readdata", readdata, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        rd(5'h02, 16'h869F, "midrst_ch0_period_lo");
        rd(5'h00, 16'h0000, "midrst_ch0_status");
        rd(5'h01, 16'h0000, "midrst_ch0_control");

        // Single-channel build: channel 1 addresses are dead.
        tgt_one = 1'b1;
        wr(5'h0A, 16'h1234);
        rd(5'h02, 16'h869F, "one_ch0_period_lo");
        rd(5'h03, 16'h0001, "one_ch0_period_hi");
        rd(5'h0A, 16'h0000, "one_ch1_read_zero");
        tick();
        tick();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending reads expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
